// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-bundle layout for the RV32I/M decode stage.
// Register fields are kept at their native 5-bit instruction width here.
package decode_pkg;

    typedef enum logic [3:0] {
        OPC_NONE   = 4'd0,
        OPC_R      = 4'd1,
        OPC_LOAD   = 4'd2,
        OPC_IMM    = 4'd3,
        OPC_LUI    = 4'd4,
        OPC_AUIPC  = 4'd5,
        OPC_JAL    = 4'd6,
        OPC_JALR   = 4'd7,
        OPC_BRANCH = 4'd8,
        OPC_STORE  = 4'd9
    } op_class_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_AND    = 5'd2,  ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,  ALU_SLL    = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,  ALU_SLTU   = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU  = 5'd13, ALU_DIV    = 5'd14, ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16, ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        JMP_NONE   = 2'b00,
        JMP_JUMP   = 2'b01,
        JMP_BRANCH = 2'b10
    } jump_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef struct packed {
        op_class_e   op_class;
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_type;
        logic [2:0]  br_type;
        jump_e       jump;
        logic        illegal;
    } decoded_t;

    // Base integer ALU op selected by funct3 (SUB/SRA variants are resolved by the caller).
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write bit per architectural register; a same-cycle writeback releases
// its register for the hazard query, and a new set wins over any clear.
module decode_scoreboard #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_vld,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  wb_vld,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  kill_vld,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  hazard
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [NREG-1:0] sb_q, sb_d;
    logic [NREG-1:0] sb_eff, wb_mask, kill_mask, set_mask;

    always_comb begin
        wb_mask   = '0;
        kill_mask = '0;
        set_mask  = '0;
        if (wb_vld)   wb_mask[wb_rd]     = 1'b1;
        if (kill_vld) kill_mask[kill_rd] = 1'b1;
        if (set_vld)  set_mask[set_rd]   = 1'b1;
        sb_eff = sb_q & ~wb_mask;
        // Callers pass 0 for unused fields, and bit 0 is never set, so no per-field enables.
        hazard = sb_eff[rs1] | sb_eff[rs2] | sb_eff[rd];
        sb_d   = (sb_eff & ~kill_mask) | set_mask;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) sb_q <= '0;
        else     sb_q <= sb_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/M decoder between fetch and execute with scoreboard-based RAW/WAW stall.
// One-cycle latency; holds its output while execute stalls and refuses input on hazard or flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter bit ENABLE_MEXT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [3:0]            out_op_class,
    output logic [4:0]            out_alu_op,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic [2:0]            out_mem_type,
    output logic [2:0]            out_br_type,
    output logic [1:0]            out_jump,
    output logic [XLEN-1:0]       out_imm,
    output logic                  out_illegal,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] f_rs1, f_rs2, f_rd;
    decoded_t   dec;
    logic [31:0] imm32;
    logic       legal;

    assign opcode = in_instr[6:0];
    assign f_rd   = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign f_rs1  = in_instr[19:15];
    assign f_rs2  = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec   = '0;
        imm32 = '0;
        legal = 1'b1;
        case (opcode)
            OPCODE_OP: begin
                dec.op_class = OPC_R;
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.rd = f_rd; dec.rd_we = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_MEXT) dec.alu_op = alu_op_e'(5'd10 + {2'b00, funct3});
                    else             legal = 1'b0;
                end else if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_from_f3(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPCODE_IMM: begin
                dec.op_class = OPC_IMM;
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.rd_we = 1'b1;
                dec.alu_op = alu_from_f3(funct3);
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                // Shift-immediates reuse funct7 as an opcode extension, so other values are reserved.
                if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      dec.alu_op = ALU_SRA;
                    else if (funct7 != 7'b0000000) legal = 1'b0;
                end
            end
            OPCODE_LOAD: begin
                dec.op_class = OPC_LOAD;
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.rd_we = 1'b1;
                dec.mem_rd = 1'b1; dec.mem_type = funct3;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) legal = 1'b0;
            end
            OPCODE_STORE: begin
                dec.op_class = OPC_STORE;
                dec.rs1 = f_rs1; dec.rs2 = f_rs2;
                dec.mem_wr = 1'b1; dec.mem_type = funct3;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                if (funct3[2] || funct3 == 3'b011) legal = 1'b0;
            end
            OPCODE_BRANCH: begin
                dec.op_class = OPC_BRANCH;
                dec.rs1 = f_rs1; dec.rs2 = f_rs2;
                dec.jump = JMP_BRANCH; dec.br_type = funct3;
                dec.alu_op = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
                if (funct3[2:1] == 2'b01) legal = 1'b0;
            end
            OPCODE_LUI: begin
                dec.op_class = OPC_LUI;
                dec.rd = f_rd; dec.rd_we = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OPCODE_AUIPC: begin
                dec.op_class = OPC_AUIPC;
                dec.rd = f_rd; dec.rd_we = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                dec.op_class = OPC_JAL;
                dec.rd = f_rd; dec.rd_we = 1'b1; dec.jump = JMP_JUMP;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            end
            OPCODE_JALR: begin
                dec.op_class = OPC_JALR;
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.rd_we = 1'b1; dec.jump = JMP_JUMP;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (funct3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // Illegal instructions travel as an inert bundle so they cannot stall or claim a register.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm32       = '0;
        end
    end

    logic            out_valid_q, out_valid_d;
    decoded_t        bundle_q, bundle_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
    logic            hazard, accept;

    decode_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (accept && dec.rd_we && dec.rd != 5'd0),
        .set_rd   (REG_ADDR_W'(dec.rd)),
        .wb_vld   (wb_valid),
        .wb_rd    (wb_rd),
        .kill_vld (flush && out_valid_q && bundle_q.rd_we),
        .kill_rd  (REG_ADDR_W'(bundle_q.rd)),
        .rs1      (REG_ADDR_W'(dec.rs1)),
        .rs2      (REG_ADDR_W'(dec.rs2)),
        .rd       (REG_ADDR_W'(dec.rd)),
        .hazard   (hazard)
    );

    assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            pc_d        = in_pc;
            imm_d       = XLEN'($signed(imm32));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm_q;
    assign out_op_class = bundle_q.op_class;
    assign out_alu_op   = bundle_q.alu_op;
    assign out_rs1      = REG_ADDR_W'(bundle_q.rs1);
    assign out_rs2      = REG_ADDR_W'(bundle_q.rs2);
    assign out_rd       = REG_ADDR_W'(bundle_q.rd);
    assign out_rd_we    = bundle_q.rd_we;
    assign out_mem_rd   = bundle_q.mem_rd;
    assign out_mem_wr   = bundle_q.mem_wr;
    assign out_mem_type = bundle_q.mem_type;
    assign out_br_type  = bundle_q.br_type;
    assign out_jump     = bundle_q.jump;
    assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with the M extension, one without,
// driven by the same stimulus.
module tb_decode_stage;
    logic        clk, rst, in_valid, out_ready, wb_valid, flush;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, out_rd_we, out_mem_rd, out_mem_wr, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_op_class;
    logic [4:0]  out_alu_op, out_rs1, out_rs2, out_rd;
    logic [2:0]  out_mem_type, out_br_type;
    logic [1:0]  out_jump;

    logic        nm_in_ready, nm_out_valid, nm_rd_we, nm_mem_rd, nm_mem_wr, nm_illegal;
    logic [31:0] nm_pc, nm_imm;
    logic [3:0]  nm_op_class;
    logic [4:0]  nm_alu_op, nm_rs1, nm_rs2, nm_rd;
    logic [2:0]  nm_mem_type, nm_br_type;
    logic [1:0]  nm_jump;

    int errors = 0;
    int checks = 0;

    decode_stage #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_MEXT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op_class(out_op_class), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_mem_type(out_mem_type), .out_br_type(out_br_type),
        .out_jump(out_jump), .out_imm(out_imm), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    decode_stage #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_MEXT(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready), .out_pc(nm_pc),
        .out_op_class(nm_op_class), .out_alu_op(nm_alu_op), .out_rs1(nm_rs1),
        .out_rs2(nm_rs2), .out_rd(nm_rd), .out_rd_we(nm_rd_we), .out_mem_rd(nm_mem_rd),
        .out_mem_wr(nm_mem_wr), .out_mem_type(nm_mem_type), .out_br_type(nm_br_type),
        .out_jump(nm_jump), .out_imm(nm_imm), .out_illegal(nm_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_sb", dut.u_sb.sb_q, 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; #1;
        chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_rd", {27'b0, out_rd}, 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_alu", {27'b0, out_alu_op}, 32'd0);
        chk("addi_rd_we", {31'b0, out_rd_we}, 32'd1);
        chk("addi_class", {28'b0, out_op_class}, 32'd3);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_sb", dut.u_sb.sb_q, 32'h2);

        // ADD x2,x1,x1 stalls on x1 until its writeback
        in_instr = 32'h00108133; in_pc = 32'h104; #1;
        chk("add_stall", {31'b0, in_ready}, 32'd0);
        tick();
        chk("add_bubble", {31'b0, out_valid}, 32'd0);
        chk("add_stall2", {31'b0, in_ready}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd1; #1;
        chk("add_release", {31'b0, in_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_rd", {27'b0, out_rd}, 32'd2);
        chk("add_rs1", {27'b0, out_rs1}, 32'd1);
        chk("add_rs2", {27'b0, out_rs2}, 32'd1);
        chk("add_class", {28'b0, out_op_class}, 32'd1);
        chk("add_sb", dut.u_sb.sb_q, 32'h4);

        // LW x3,8(x2) accepted alongside writeback of x2, then held for 3 cycles
        in_instr = 32'h00812183; in_pc = 32'h108; wb_valid = 1'b1; wb_rd = 5'd2; #1;
        chk("lw_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'hFE20CEE3; in_pc = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("lw_mem_rd", {31'b0, out_mem_rd}, 32'd1);
            chk("lw_mem_type", {29'b0, out_mem_type}, 32'd2);
            chk("lw_imm", out_imm, 32'd8);
            chk("lw_rd", {27'b0, out_rd}, 32'd3);
            chk("lw_pc", out_pc, 32'h108);
            chk("lw_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        chk("lw_sb", dut.u_sb.sb_q, 32'h8);

        // BLT x1,x2,-4
        out_ready = 1'b1; #1;
        chk("blt_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("blt_jump", {30'b0, out_jump}, 32'd2);
        chk("blt_br_type", {29'b0, out_br_type}, 32'd4);
        chk("blt_imm", out_imm, 32'hFFFFFFFC);
        chk("blt_rd_we", {31'b0, out_rd_we}, 32'd0);
        chk("blt_alu", {27'b0, out_alu_op}, 32'd1);
        chk("blt_class", {28'b0, out_op_class}, 32'd8);
        chk("blt_sb", dut.u_sb.sb_q, 32'h8);

        // all-zero word is illegal and inert
        in_instr = 32'h00000000; in_pc = 32'h200;
        tick();
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_flag", {31'b0, out_illegal}, 32'd1);
        chk("ill_rd_we", {31'b0, out_rd_we}, 32'd0);
        chk("ill_mem", {30'b0, out_mem_rd, out_mem_wr}, 32'd0);
        chk("ill_jump", {30'b0, out_jump}, 32'd0);
        chk("ill_sb", dut.u_sb.sb_q, 32'h8);

        // MUL x5,x6,x7 on both configurations
        in_instr = 32'h027302B3; in_pc = 32'h204;
        tick();
        chk("mul_alu", {27'b0, out_alu_op}, 32'd10);
        chk("mul_illegal", {31'b0, out_illegal}, 32'd0);
        chk("mul_rd", {27'b0, out_rd}, 32'd5);
        chk("nomext_valid", {31'b0, nm_out_valid}, 32'd1);
        chk("nomext_illegal", {31'b0, nm_illegal}, 32'd1);
        chk("nomext_rd_we", {31'b0, nm_rd_we}, 32'd0);

        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3;
        tick();
        wb_rd = 5'd5;
        tick();
        wb_valid = 1'b0;
        chk("drain_sb", dut.u_sb.sb_q, 32'h0);

        // flush while ADDI x4,x0,1 is held
        in_valid = 1'b1; in_instr = 32'h00100213; in_pc = 32'h300; out_ready = 1'b0;
        tick();
        chk("addi4_valid", {31'b0, out_valid}, 32'd1);
        chk("addi4_sb", dut.u_sb.sb_q, 32'h10);
        in_instr = 32'h00000013; out_ready = 1'b1; flush = 1'b1; #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_sb", dut.u_sb.sb_q, 32'h0);

        // reset while ADD x6,x4,x4 is stalled on x4
        in_valid = 1'b1; in_instr = 32'h00100213; in_pc = 32'h400;
        tick();
        in_instr = 32'h00420333; in_pc = 32'h404; #1;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst2_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_rd", {27'b0, out_rd}, 32'd0);
        chk("rst2_imm", out_imm, 32'd0);
        chk("rst2_pc", out_pc, 32'd0);
        chk("rst2_class", {28'b0, out_op_class}, 32'd0);
        chk("rst2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst2_sb", dut.u_sb.sb_q, 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
